// File: rtl/match_score_keeper.sv
// Two-player Pong score keeper: match FSM, win/deuce rules, serve rotation
// and BCD score mirrors for the HEX displays.
module match_score_keeper #(
  parameter int unsigned SCORE_WIDTH    = 6,
  parameter int unsigned WIN_SCORE      = 11,
  parameter int unsigned WIN_MARGIN     = 2,
  parameter int unsigned SERVE_INTERVAL = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   first_serve_right,
  input  logic                   left_point,
  input  logic                   right_point,
  output logic [SCORE_WIDTH-1:0] left_score,
  output logic [SCORE_WIDTH-1:0] right_score,
  output logic [7:0]             left_bcd,
  output logic [7:0]             right_bcd,
  output logic                   serve_right,
  output logic                   in_play,
  output logic                   game_over,
  output logic                   left_won,
  output logic                   right_won,
  output logic                   point_ack
);

  localparam int unsigned MAX_SCORE = (32'd1 << SCORE_WIDTH) - 32'd1;
  localparam int unsigned CNT_W     = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SCORE_WIDTH-1:0] left_score_q, left_score_d;
  logic [SCORE_WIDTH-1:0] right_score_q, right_score_d;
  logic [7:0]             left_bcd_q, left_bcd_d;
  logic [7:0]             right_bcd_q, right_bcd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   serve_right_q, serve_right_d;
  logic                   in_play_q, in_play_d;
  logic                   game_over_q, game_over_d;
  logic                   left_won_q, left_won_d;
  logic                   right_won_q, right_won_d;
  logic                   point_ack_q, point_ack_d;

  logic [SCORE_WIDTH-1:0] l_new, r_new, s_new, o_new;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   win, deuce;

  // Decimal increment of a {tens, ones} BCD pair; ones wrap 9 -> 0 with carry.
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b[3:0] == 4'd9) bcd_inc = {b[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {b[7:4], b[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    left_bcd_d    = left_bcd_q;
    right_bcd_d   = right_bcd_q;
    cnt_d         = cnt_q;
    serve_right_d = serve_right_q;
    in_play_d     = in_play_q;
    game_over_d   = game_over_q;
    left_won_d    = left_won_q;
    right_won_d   = right_won_q;
    point_ack_d   = 1'b0;
    l_new         = left_score_q;
    r_new         = right_score_q;
    s_new         = left_score_q;
    o_new         = right_score_q;
    cnt_inc       = cnt_q + CNT_W'(1);
    win           = 1'b0;
    deuce         = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d       = ST_PLAY;
          left_score_d  = '0;
          right_score_d = '0;
          left_bcd_d    = 8'h00;
          right_bcd_d   = 8'h00;
          cnt_d         = '0;
          serve_right_d = first_serve_right;
          in_play_d     = 1'b1;
          game_over_d   = 1'b0;
          left_won_d    = 1'b0;
          right_won_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        // Simultaneous points are treated as a collision and dropped.
        if (left_point ^ right_point) begin
          l_new = left_point  ? left_score_q  + SCORE_WIDTH'(1) : left_score_q;
          r_new = right_point ? right_score_q + SCORE_WIDTH'(1) : right_score_q;
          s_new = left_point ? l_new : r_new;
          o_new = left_point ? r_new : l_new;
          left_score_d  = l_new;
          right_score_d = r_new;
          if (left_point) left_bcd_d  = bcd_inc(left_bcd_q);
          else            right_bcd_d = bcd_inc(right_bcd_q);
          point_ack_d = 1'b1;

          win = (32'(s_new) >= WIN_SCORE && 32'(s_new) >= 32'(o_new) + WIN_MARGIN)
             || (32'(s_new) == MAX_SCORE);
          deuce = (32'(l_new) + 32'd1 >= WIN_SCORE) && (32'(r_new) + 32'd1 >= WIN_SCORE);

          if (win) begin
            state_d     = ST_OVER;
            in_play_d   = 1'b0;
            game_over_d = 1'b1;
            left_won_d  = left_point;
            right_won_d = right_point;
            cnt_d       = cnt_inc;
          end else if (deuce) begin
            cnt_d         = '0;
            serve_right_d = ~serve_right_q;
          end else if (cnt_inc == CNT_W'(SERVE_INTERVAL)) begin
            cnt_d         = '0;
            serve_right_d = ~serve_right_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      left_score_q  <= '0;
      right_score_q <= '0;
      left_bcd_q    <= 8'h00;
      right_bcd_q   <= 8'h00;
      cnt_q         <= '0;
      serve_right_q <= 1'b0;
      in_play_q     <= 1'b0;
      game_over_q   <= 1'b0;
      left_won_q    <= 1'b0;
      right_won_q   <= 1'b0;
      point_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      left_bcd_q    <= left_bcd_d;
      right_bcd_q   <= right_bcd_d;
      cnt_q         <= cnt_d;
      serve_right_q <= serve_right_d;
      in_play_q     <= in_play_d;
      game_over_q   <= game_over_d;
      left_won_q    <= left_won_d;
      right_won_q   <= right_won_d;
      point_ack_q   <= point_ack_d;
    end
  end

  assign left_score  = left_score_q;
  assign right_score = right_score_q;
  assign left_bcd    = left_bcd_q;
  assign right_bcd   = right_bcd_q;
  assign serve_right = serve_right_q;
  assign in_play     = in_play_q;
  assign game_over   = game_over_q;
  assign left_won    = left_won_q;
  assign right_won   = right_won_q;
  assign point_ack   = point_ack_q;

endmodule

// File: tb/tb_match_score_keeper.sv
// Directed bench for match_score_keeper: default build (d0) and a
// 4-bit / margin-3 build (d1) driven from the same inputs.
module tb_match_score_keeper;

  logic clock = 1'b0;
  logic reset_n, start, first_serve_right, left_point, right_point;

  logic [5:0] d0_left_score, d0_right_score;
  logic [7:0] d0_left_bcd, d0_right_bcd;
  logic       d0_serve_right, d0_in_play, d0_game_over, d0_left_won, d0_right_won, d0_point_ack;

  logic [3:0] d1_left_score, d1_right_score;
  logic [7:0] d1_left_bcd, d1_right_bcd;
  logic       d1_serve_right, d1_in_play, d1_game_over, d1_left_won, d1_right_won, d1_point_ack;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  match_score_keeper u_d0 (
    .clock(clock), .reset_n(reset_n), .start(start), .first_serve_right(first_serve_right),
    .left_point(left_point), .right_point(right_point),
    .left_score(d0_left_score), .right_score(d0_right_score),
    .left_bcd(d0_left_bcd), .right_bcd(d0_right_bcd), .serve_right(d0_serve_right),
    .in_play(d0_in_play), .game_over(d0_game_over), .left_won(d0_left_won),
    .right_won(d0_right_won), .point_ack(d0_point_ack)
  );

  match_score_keeper #(.SCORE_WIDTH(4), .WIN_SCORE(11), .WIN_MARGIN(3), .SERVE_INTERVAL(2)) u_d1 (
    .clock(clock), .reset_n(reset_n), .start(start), .first_serve_right(first_serve_right),
    .left_point(left_point), .right_point(right_point),
    .left_score(d1_left_score), .right_score(d1_right_score),
    .left_bcd(d1_left_bcd), .right_bcd(d1_right_bcd), .serve_right(d1_serve_right),
    .in_play(d1_in_play), .game_over(d1_game_over), .left_won(d1_left_won),
    .right_won(d1_right_won), .point_ack(d1_point_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
  task automatic pulse(input logic l, input logic r);
    left_point  = l;
    right_point = r;
    @(posedge clock); #1;
    left_point  = 1'b0;
    right_point = 1'b0;
  endtask

  task automatic do_start(input logic fsr);
    start             = 1'b1;
    first_serve_right = fsr;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; first_serve_right = 1'b0;
    left_point = 1'b0; right_point = 1'b0;
    #12;
    check("rst_lscore", 32'(d0_left_score), 0);
    check("rst_rbcd",   32'(d0_right_bcd), 32'h00);
    check("rst_flags",  32'({d0_serve_right, d0_in_play, d0_game_over, d0_left_won, d0_right_won, d0_point_ack}), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Points in IDLE are ignored
    pulse(1'b1, 1'b0);
    check("idle_pt_score", 32'(d0_left_score), 0);
    check("idle_pt_ack",   32'(d0_point_ack), 0);

    do_start(1'b0);
    check("start_inplay", 32'(d0_in_play), 1);
    check("start_scores", 32'({d0_left_score, d0_right_score}), 0);
    check("start_serve",  32'(d0_serve_right), 0);

    // Eleven straight left points
    for (int i = 1; i <= 10; i++) pulse(1'b1, 1'b0);
    check("l10_bcd",  32'(d0_left_bcd), 32'h10);
    check("l10_play", 32'(d0_in_play), 1);
    pulse(1'b1, 1'b0);
    check("l11_score", 32'(d0_left_score), 11);
    check("l11_bcd",   32'(d0_left_bcd), 32'h11);
    check("l11_won",   32'({d0_left_won, d0_right_won}), 32'b10);
    check("l11_over",  32'({d0_game_over, d0_in_play}), 32'b10);
    check("l11_ack",   32'(d0_point_ack), 1);
    pulse(1'b0, 1'b1);
    check("over_pt_score", 32'(d0_right_score), 0);
    check("over_pt_ack",   32'(d0_point_ack), 0);
    check("over_hold_l",   32'(d0_left_score), 11);

    // Deuce game: 10-10, then two left points
    do_start(1'b0);
    check("restart_clear", 32'({d0_left_score, d0_left_won, d0_game_over}), 0);
    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    check("d10_scores", 32'({d0_left_score, d0_right_score}), {26'd0, 6'd10, 6'd10} & 32'hfff);
    check("d10_serve",  32'(d0_serve_right), 0);
    pulse(1'b1, 1'b0);
    check("d11_nowin",  32'({d0_left_won, d0_game_over, d0_in_play}), 32'b001);
    check("d11_serve",  32'(d0_serve_right), 1);
    pulse(1'b1, 1'b0);
    check("d12_won",    32'({d0_left_won, d0_game_over}), 32'b11);
    check("d12_serve",  32'(d0_serve_right), 1);
    check("d12_bcd",    32'(d0_left_bcd), 32'h12);
    check("d12_rbcd",   32'(d0_right_bcd), 32'h10);

    // Collision at 3-2 leaves scores and serve counter untouched
    do_start(1'b0);
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0);
    check("c32_serve", 32'(d0_serve_right), 0);
    pulse(1'b1, 1'b1);
    check("coll_left",  32'(d0_left_score), 3);
    check("coll_right", 32'(d0_right_score), 2);
    check("coll_ack",   32'(d0_point_ack), 0);
    check("coll_serve", 32'(d0_serve_right), 0);
    pulse(1'b0, 1'b1);
    check("c33_serve",  32'(d0_serve_right), 1);

    // Serve rotation from a right-side first serve
    do_reset();
    do_start(1'b1);
    check("s0_serve", 32'(d0_serve_right), 1);
    pulse(1'b0, 1'b1); check("s1_serve", 32'(d0_serve_right), 1);
    pulse(1'b0, 1'b1); check("s2_serve", 32'(d0_serve_right), 0);
    pulse(1'b0, 1'b1); check("s3_serve", 32'(d0_serve_right), 0);
    pulse(1'b0, 1'b1); check("s4_serve", 32'(d0_serve_right), 1);
    check("s4_bcd", 32'(d0_right_bcd), 32'h04);

    // A point coinciding with start is dropped
    do_reset();
    start = 1'b1; first_serve_right = 1'b0; left_point = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; left_point = 1'b0;
    check("stpt_inplay", 32'(d0_in_play), 1);
    check("stpt_score",  32'(d0_left_score), 0);
    check("stpt_ack",    32'(d0_point_ack), 0);

    // Narrow build: alternate to 14-14, then saturation win at 15
    for (int i = 0; i < 14; i++) begin
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    check("n14_play",  32'({d1_in_play, d1_left_won, d1_right_won}), 32'b100);
    check("n14_right", 32'(d1_right_score), 14);
    pulse(1'b1, 1'b0);
    check("n15_score", 32'(d1_left_score), 15);
    check("n15_bcd",   32'(d1_left_bcd), 32'h15);
    check("n15_won",   32'({d1_left_won, d1_right_won, d1_game_over}), 32'b101);

    // Asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    check("arst_d1_score", 32'({d1_left_score, d1_right_score}), 0);
    check("arst_d1_bcd",   32'(d1_left_bcd), 0);
    check("arst_d1_flags", 32'({d1_left_won, d1_game_over, d1_serve_right, d1_in_play}), 0);
    check("arst_d0_play",  32'({d0_in_play, d0_right_score}), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/match_score_keeper.md
# match_score_keeper

Parametrised two-player Pong score keeper with a match state machine, configurable win score and win-by margin, serve tracking and registered BCD score outputs for the HEX displays. It sits between the ball location processor, which pulses a point for the scoring side, and the HEX decoders and screen logic, which consume scores, the winner and the serving side.

## Interface
- SCORE_WIDTH, 6: score register width, legal range 4..6; MAX = 2^SCORE_WIDTH-1.
- WIN_SCORE, 11: minimum score to win; must satisfy 1 <= WIN_SCORE <= MAX.
- WIN_MARGIN, 2: required lead over the opponent at the win check; legal range 1..3.
- SERVE_INTERVAL, 2: number of total points between serve changes; legal range 1..7.
- clock  in  1  single system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER.
- first_serve_right  in  1  serving side for the new game, sampled when start is accepted.
- left_point / right_point  in  1 each  one point per asserted cycle.
- left_score / right_score  out  SCORE_WIDTH each  binary scores.
- left_bcd / right_bcd  out  8 each  {tens, ones} BCD of the matching score.
- serve_right  out  1  1 = right player serves.
- in_play  out  1  FSM is in PLAY.
- game_over  out  1  FSM is in OVER.
- left_won / right_won  out  1 each  winner flags, one-hot or both 0.
- point_ack  out  1  one-cycle pulse when a point is counted.

## Operation
- States: IDLE (entered after reset), PLAY, OVER.
- IDLE/OVER + start -> PLAY:
  - clear both scores, both BCD values, the point counter, the won flags and game_over.
  - load serve_right from first_serve_right.
- In PLAY, start is ignored. In IDLE and OVER, points are ignored.
- In PLAY, exactly one of left_point/right_point high:
  - increment that score and its BCD value in parallel. Ones digit wraps 9 -> 0 and carries into tens. The BCD value is never derived by division.
  - pulse point_ack.
  - increment the 3-bit total-point counter.
- In PLAY, both point inputs high in the same cycle: nothing changes and point_ack stays 0.
- A point arriving in the same cycle as start is ignored.
- Win check uses the post-increment score S of the scorer and the opponent score O:
  - win if S >= WIN_SCORE and S - O >= WIN_MARGIN, or if S == MAX (the saturation rule, which overrides the margin).
  - on a win: FSM -> OVER, the scorer's won flag goes high, game_over goes high.
- A score never exceeds MAX. The saturation rule ends the game before any further increment is possible.
- Serve control, applied on each counted point:
  - Deuce condition: both post-update scores >= WIN_SCORE-1. Under deuce, serve_right toggles on every point and the counter is held at 0.
  - Otherwise, when the counter reaches SERVE_INTERVAL, it resets to 0 and serve_right toggles.
  - No serve toggle on the point that ends the game.
- OVER holds scores, BCD values, won flags and serve_right until start.

## Timing
- Reset values: left_score = right_score = 0, left_bcd = right_bcd = 8'h00, serve_right = 0, in_play = 0, game_over = 0, left_won = right_won = 0, point_ack = 0, FSM in IDLE.
- All outputs are registered with no combinational input-to-output paths.
- Latency: an input asserted in cycle N shows its effect on outputs in cycle N+1. This covers the score, BCD, point_ack, serve_right, won flags and the state change.
- start in cycle N: in_play = 1 and scores = 0 in cycle N+1.
- point_ack is high for exactly one cycle per counted point. A point input held high for k cycles in PLAY counts k points.
- Upstream must pulse the point inputs. The block does no edge detection.
- Reset asserted mid-game: all outputs take their reset values immediately, without waiting for a clock edge. Deassertion is synchronised upstream.

## Test plan
- Reset, then start with first_serve_right = 0:
  - before start, all reset values hold.
  - cycle after start: in_play = 1, scores 0, serve_right = 0.
- Eleven left_point pulses in the default configuration:
  - left_score = 11, left_bcd = 8'h11, left_won = 1, game_over = 1, all one cycle after the 11th pulse.
  - a further right_point pulse: no change, point_ack = 0.
- Alternate points to 10-10, then left, left:
  - at 11-10 there is no win and serve_right toggles.
  - at 12-10, left_won = 1 and serve_right is unchanged.
- left_point and right_point high together at 3-2 in PLAY: scores stay 3-2, point_ack = 0, the counter is unchanged.
- SERVE_INTERVAL = 2, first_serve_right = 1, four right points: serve_right reads 1, 0, 0, 1 after points 1-4; BCD reads 8'h04.
- SCORE_WIDTH = 4, WIN_SCORE = 11, WIN_MARGIN = 3:
  - alternate points to 14-14, then left_point: left_score = 15, left_won = 1.
  - then assert reset_n = 0 mid-cycle: outputs clear before the next clock edge.
